// File: rtl/ntt_pkg.sv
// Shared types and arithmetic helpers for the iterative NTT core and its butterfly.
package ntt_pkg;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_UNLOAD  = 2'd2
   } state_t;

   // Widest coefficient the helpers handle; callers zero-extend W-bit operands.
   localparam int WMAX = 32;
   // Widest index bitrev handles (N up to 1024).
   localparam int REVW = 10;

   // Reverse the low nbits bits of value; upper result bits are zero.
   function automatic logic [REVW-1:0] bitrev(input logic [REVW-1:0] value, input int nbits);
      logic [REVW-1:0] r;
      r = '0;
      for (int i = 0; i < REVW; i++) begin
         if (i < nbits) r[i] = value[nbits-1-i];
      end
      return r;
   endfunction

   // (a*b) mod q with a full double-width product.
   function automatic logic [WMAX-1:0] modmul(input logic [WMAX-1:0] a, input logic [WMAX-1:0] b,
                                              input logic [WMAX-1:0] q);
      logic [2*WMAX-1:0] p;
      logic [2*WMAX-1:0] r;
      p = {{WMAX{1'b0}}, a} * {{WMAX{1'b0}}, b};
      r = p % {{WMAX{1'b0}}, q};
      return r[WMAX-1:0];
   endfunction

   // (a+b) mod q; operands are already reduced, so one conditional subtract suffices.
   function automatic logic [WMAX-1:0] modadd(input logic [WMAX-1:0] a, input logic [WMAX-1:0] b,
                                              input logic [WMAX-1:0] q);
      logic [WMAX:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
      return s[WMAX-1:0];
   endfunction

   // (a-b+q) mod q; operands are already reduced.
   function automatic logic [WMAX-1:0] modsub(input logic [WMAX-1:0] a, input logic [WMAX-1:0] b,
                                              input logic [WMAX-1:0] q);
      logic [WMAX:0] s;
      s = {1'b0, a} + {1'b0, q} - {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
      return s[WMAX-1:0];
   endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational Cooley-Tukey butterfly: x = u + v*tw, y = u - v*tw, all mod q.
module ntt_butterfly #(
   parameter int W = 16
) (
   input  logic [W-1:0] u_i,
   input  logic [W-1:0] v_i,
   input  logic [W-1:0] tw_i,
   input  logic [W-1:0] q_i,
   output logic [W-1:0] x_o,
   output logic [W-1:0] y_o
);
   import ntt_pkg::*;

   logic [WMAX-1:0] t;

   // Twiddle product then the sum/difference pair, widened to the helper width.
   always_comb begin
      t   = modmul(WMAX'(v_i), WMAX'(tw_i), WMAX'(q_i));
      x_o = W'(modadd(WMAX'(u_i), t, WMAX'(q_i)));
      y_o = W'(modsub(WMAX'(u_i), t, WMAX'(q_i)));
   end

endmodule

// File: rtl/ntt_iter_core.sv
// Sequential radix-2 DIT forward NTT: bit-reversed load, one butterfly per cycle,
// natural-order unload over valid/ready streams.
module ntt_iter_core #(
   parameter int N    = 16,
   parameter int W    = 16,
   parameter int LOGN = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [W-1:0]    mod,
   input  logic            tw_wr_en,
   input  logic [LOGN-2:0] tw_wr_addr,
   input  logic [W-1:0]    tw_wr_data,
   input  logic            in_valid,
   input  logic [W-1:0]    in_data,
   output logic            in_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   input  logic            out_ready,
   output logic            busy
);
   import ntt_pkg::*;

   localparam int SW = $clog2(LOGN) + 1;   // stage counter, room for stage+1
   localparam int HW = LOGN - 1;           // butterfly/twiddle index width

   state_t          state_q, state_d;
   logic [LOGN-1:0] cnt_q, cnt_d;
   logic [LOGN-1:0] ocnt_q, ocnt_d;
   logic [HW-1:0]   bf_q, bf_d;
   logic [SW-1:0]   stage_q, stage_d;
   logic            bubble_q, bubble_d;
   logic [W-1:0]    q_q, q_d;

   logic [W-1:0]    mem_q [N];
   logic [W-1:0]    tw_q  [N/2];

   logic            wb_valid_q;
   logic [LOGN-1:0] wb_a_q, wb_b_q;
   logic [W-1:0]    wb_x_q, wb_y_q;

   logic            in_fire, out_fire, issue;
   logic [W-1:0]    q_eff, load_val;
   logic [LOGN-1:0] load_addr;
   logic [LOGN-1:0] i_ext, half, kk, a_addr, b_addr;
   logic [HW-1:0]   tw_idx;
   logic [W-1:0]    bf_x, bf_y;

   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_UNLOAD);
   assign busy      = (state_q == ST_COMPUTE);
   assign out_data  = out_valid ? mem_q[ocnt_q] : '0;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign issue     = busy & ~bubble_q;

   // The first word of a transform uses the live modulus; later words use the latched one.
   assign q_eff     = (cnt_q == '0) ? mod : q_q;
   assign load_val  = in_data % q_eff;
   assign load_addr = LOGN'(bitrev(REVW'(cnt_q), LOGN));

   // Map (stage, butterfly index) to the a/b addresses and twiddle index.
   always_comb begin
      i_ext  = {1'b0, bf_q};
      half   = LOGN'(1) << stage_q;
      kk     = i_ext & (half - LOGN'(1));
      a_addr = ((i_ext >> stage_q) << (stage_q + SW'(1))) | kk;
      b_addr = a_addr | half;
      tw_idx = HW'(kk << (SW'(LOGN - 1) - stage_q));
   end

   ntt_butterfly #(.W(W)) u_bfly (
      .u_i  (mem_q[a_addr]),
      .v_i  (mem_q[b_addr]),
      .tw_i (tw_q[tw_idx]),
      .q_i  (q_q),
      .x_o  (bf_x),
      .y_o  (bf_y)
   );

   // Next-state logic for the FSM and its load/compute/unload counters.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ocnt_d   = ocnt_q;
      bf_d     = bf_q;
      stage_d  = stage_q;
      bubble_d = bubble_q;
      q_d      = q_q;
      case (state_q)
         ST_LOAD: begin
            if (in_fire) begin
               if (cnt_q == '0) q_d = mod;
               if (cnt_q == LOGN'(N - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_COMPUTE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_COMPUTE: begin
            if (!bubble_q) begin
               if (bf_q == HW'(N/2 - 1)) begin
                  bf_d     = '0;
                  bubble_d = 1'b1;
               end else begin
                  bf_d = bf_q + 1'b1;
               end
            end else begin
               // Bubble lets the stage's last write-back land before the next stage reads.
               bubble_d = 1'b0;
               if (stage_q == SW'(LOGN - 1)) begin
                  stage_d = '0;
                  state_d = ST_UNLOAD;
               end else begin
                  stage_d = stage_q + 1'b1;
               end
            end
         end
         ST_UNLOAD: begin
            if (out_fire) begin
               if (ocnt_q == LOGN'(N - 1)) begin
                  ocnt_d  = '0;
                  state_d = ST_LOAD;
               end else begin
                  ocnt_d = ocnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Control state with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_LOAD;
         cnt_q    <= '0;
         ocnt_q   <= '0;
         bf_q     <= '0;
         stage_q  <= '0;
         bubble_q <= 1'b0;
         q_q      <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ocnt_q   <= ocnt_d;
         bf_q     <= bf_d;
         stage_q  <= stage_d;
         bubble_q <= bubble_d;
         q_q      <= q_d;
      end
   end

   // Butterfly output register: results are written to memory one cycle after issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_a_q     <= '0;
         wb_b_q     <= '0;
         wb_x_q     <= '0;
         wb_y_q     <= '0;
      end else begin
         wb_valid_q <= issue;
         wb_a_q     <= a_addr;
         wb_b_q     <= b_addr;
         wb_x_q     <= bf_x;
         wb_y_q     <= bf_y;
      end
   end

   // Coefficient memory: load writes and butterfly write-back; contents survive reset.
   always_ff @(posedge clk) begin
      if (in_fire) mem_q[load_addr] <= load_val;
      if (wb_valid_q) begin
         mem_q[wb_a_q] <= wb_x_q;
         mem_q[wb_b_q] <= wb_y_q;
      end
   end

   // Twiddle table: writable only while loading, persists across transforms and reset.
   always_ff @(posedge clk) begin
      if (tw_wr_en && (state_q == ST_LOAD)) tw_q[tw_wr_addr] <= tw_wr_data;
   end

endmodule

// File: tb/tb_ntt_iter_core.sv
// Directed + randomized bench for ntt_iter_core (N=8, W=16), checked against a direct
// O(N^2) evaluation X[j] = sum_i x[i]*w^(i*j) mod q.
module tb_ntt_iter_core;

   localparam int N = 8;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] mod_v = '0;
   logic         tw_wr_en = 1'b0;
   logic [1:0]   tw_wr_addr = '0;
   logic [W-1:0] tw_wr_data = '0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready = 1'b0;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int unsigned vec   [N];
   int unsigned exp_v [N];

   ntt_iter_core #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mod        (mod_v),
      .tw_wr_en   (tw_wr_en),
      .tw_wr_addr (tw_wr_addr),
      .tw_wr_data (tw_wr_data),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int unsigned powm(input int unsigned b, input int unsigned e,
                                        input int unsigned q);
      longint unsigned r = 1;
      for (int i = 0; i < int'(e); i++) r = (r * longint'(b)) % longint'(q);
      return int'(r);
   endfunction

   // Reference: direct evaluation of the length-N transform over Z_q.
   function automatic void compute_expected(input int unsigned q, input int unsigned w);
      for (int j = 0; j < N; j++) begin
         longint unsigned acc = 0;
         for (int i = 0; i < N; i++)
            acc = (acc + longint'(vec[i] % q) * longint'(powm(w, (i * j) % N, q))) % longint'(q);
         exp_v[j] = int'(acc);
      end
   endfunction

   task automatic write_tw(input int unsigned q, input int unsigned w);
      for (int k = 0; k < N/2; k++) begin
         @(negedge clk);
         tw_wr_en   = 1'b1;
         tw_wr_addr = 2'(k);
         tw_wr_data = W'(powm(w, k, q));
      end
      @(negedge clk);
      tw_wr_en = 1'b0;
   endtask

   // Load vec, time COMPUTE, then drain; abort_at>0 resets during that COMPUTE cycle.
   task automatic run(input string name, input int unsigned q, input int unsigned w,
                      input bit chg_mod, input bit bp, input bit junk_tw, input int abort_at);
      int cyc;
      int idx;
      int c;
      bit have_hold;
      logic [W-1:0] held;
      compute_expected(q, w);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         chk({name, "_in_ready"}, in_ready, 1);
         in_valid = 1'b1;
         in_data  = W'(vec[i]);
         mod_v    = (i == 0 || !chg_mod) ? W'(q) : W'($urandom_range(2, 65535));
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk({name, "_in_ready_fall"}, in_ready, 0);
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         if (junk_tw) begin
            tw_wr_en   = 1'b1;
            tw_wr_addr = 2'($urandom_range(0, 3));
            tw_wr_data = W'($urandom_range(0, 65535));
         end
         if (cyc == abort_at) begin
            #1 rst_n = 1'b0;
            #1;
            chk({name, "_rst_busy"}, busy, 0);
            chk({name, "_rst_out_valid"}, out_valid, 0);
            chk({name, "_rst_in_ready"}, in_ready, 1);
            chk({name, "_rst_out_data"}, out_data, 0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
      end
      tw_wr_en = 1'b0;
      chk({name, "_busy_cycles"}, cyc, 15);
      chk({name, "_first_out_valid"}, out_valid, 1);
      idx = 0;
      c = 0;
      have_hold = 1'b0;
      held = '0;
      while (idx < N && c < 200) begin
         out_ready = bp ? (c % 3 == 0) : 1'b1;
         chk({name, "_out_valid"}, out_valid, 1);
         if (have_hold) chk({name, "_stall_stable"}, out_data, held);
         if (out_ready) begin
            chk($sformatf("%s_X%0d", name, idx), out_data, exp_v[idx]);
            idx++;
            have_hold = 1'b0;
         end else begin
            held = out_data;
            have_hold = 1'b1;
         end
         c++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk({name, "_drained"}, idx, N);
      chk({name, "_in_ready_rise"}, in_ready, 1);
      chk({name, "_out_valid_low"}, out_valid, 0);
      chk({name, "_out_data_idle"}, out_data, 0);
      $display("transform %s q=%0d done: %0d busy cycles, %0d output cycles", name, q, cyc, c);
   endtask

   initial begin
      // Reset state
      #12;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      write_tw(17, 2);

      // Impulse
      foreach (vec[i]) vec[i] = (i == 0) ? 1 : 0;
      run("impulse", 17, 2, 0, 0, 0, 0);

      // Constant ones
      foreach (vec[i]) vec[i] = 1;
      run("ones", 17, 2, 0, 0, 0, 0);

      // Delta at index 1, with hard expectations alongside the model
      foreach (vec[i]) vec[i] = (i == 1) ? 1 : 0;
      compute_expected(17, 2);
      chk("delta_model_X4", exp_v[4], 16);
      chk("delta_model_X7", exp_v[7], 9);
      run("delta1", 17, 2, 0, 0, 0, 0);

      // Unreduced input plus mod port wiggling after the first word
      foreach (vec[i]) vec[i] = (i == 0) ? 20 : 0;
      run("reduce_modchg", 17, 2, 1, 0, 0, 0);

      // Random data, backpressure, ignored twiddle writes during COMPUTE
      foreach (vec[i]) vec[i] = $urandom_range(0, 65535);
      run("rand_bp", 17, 2, 0, 1, 1, 0);

      // Reset in COMPUTE cycle 6, then a clean impulse on the retained twiddles
      foreach (vec[i]) vec[i] = $urandom_range(0, 65535);
      run("abort", 17, 2, 0, 0, 0, 6);
      foreach (vec[i]) vec[i] = (i == 0) ? 1 : 0;
      run("post_reset", 17, 2, 0, 0, 0, 0);

      // Different modulus and root
      write_tw(97, 64);
      foreach (vec[i]) vec[i] = $urandom_range(0, 65535);
      run("rand_q97", 97, 64, 0, 1, 0, 0);

      write_tw(17, 2);
      foreach (vec[i]) vec[i] = $urandom_range(0, 65535);
      run("rand_q17", 17, 2, 1, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
